// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between two valid/done requesters.
// Only one transaction is in flight at a time. AXI outputs are registered and change only at grant.
module axi_lite_arbiter #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*(DATA_W/8)-1:0] req_wstrb,
  output logic [1:0]              req_done,
  output logic [DATA_W-1:0]       req_rdata,
  output logic [1:0]              req_resp,
  output logic                    busy,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [ADDR_W-1:0]       M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  output logic [DATA_W-1:0]       M_AXI_WDATA,
  output logic [DATA_W/8-1:0]     M_AXI_WSTRB,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  input  logic [1:0]              M_AXI_BRESP,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  output logic [ADDR_W-1:0]       M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  input  logic [DATA_W-1:0]       M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;

  logic                gnt;
  logic                aw_hs, w_hs;

  // Sole requester wins; on a tie the one not granted last time wins.
  always_comb begin
    gnt = ~last_grant_q;
    if (req_valid == 2'b01) gnt = 1'b0;
    else if (req_valid == 2'b10) gnt = 1'b1;
  end

  // A beat transfers on a rising edge where VALID and READY are both high;
  // VALID is held, with stable payload, until that edge and dropped right after it.
  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q & M_AXI_WREADY;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          last_grant_d = gnt;
          grant_d      = gnt;
          addr_d       = gnt ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
          wdata_d      = gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          wstrb_d      = gnt ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          if (req_we[gnt]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WADDR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bready_q && M_AXI_BVALID) begin
          resp_d   = M_AXI_BRESP;
          bready_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_RADDR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (rready_q && M_AXI_RVALID) begin
          rdata_d  = M_AXI_RDATA;
          resp_d   = M_AXI_RRESP;
          rready_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  assign req_done      = (state_q == S_DONE) ? {grant_q, ~grant_q} : 2'b00;
  assign req_rdata     = rdata_q;
  assign req_resp      = resp_q;
  assign busy          = (state_q != S_IDLE);
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: wait-configurable AXI slave model, two requester drivers,
// per-requester expected queues checked on every done pulse.
module tb_axi_lite_arbiter;

  localparam int EW = 71; // {we, addr[31:0], data[31:0], strb[3:0], resp[1:0]}

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic [1:0]  req_done;
  logic [31:0] req_rdata;
  logic [1:0]  req_resp;
  logic        busy;
  logic        M_AXI_AWVALID, M_AXI_AWREADY = 1'b0;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_WVALID, M_AXI_WREADY = 1'b0;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_BVALID = 1'b0, M_AXI_BREADY;
  logic [1:0]  M_AXI_BRESP = '0;
  logic        M_AXI_ARVALID, M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_RVALID = 1'b0, M_AXI_RREADY;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int done_log[$];

  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  bit rand_mode = 1'b0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;

  axi_lite_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp), .busy(busy),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Slave response model: response code comes from address bits [13:12], read data is addr ^ 0x1234.
  function automatic logic [1:0] resp_fn(input logic [31:0] a);
    return a[13:12];
  endfunction

  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    return a ^ 32'h0000_1234;
  endfunction

  // ---------------- AXI slave model ----------------
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (M_AXI_AWVALID) begin
          if (aw_cnt >= aw_wait) M_AXI_AWREADY = 1'b1;
          else begin M_AXI_AWREADY = 1'b0; aw_cnt++; end
        end else begin
          M_AXI_AWREADY = 1'b0; aw_cnt = 0;
          if (rand_mode) aw_wait = $urandom_range(0, 3);
        end
        if (M_AXI_WVALID) begin
          if (w_cnt >= w_wait) M_AXI_WREADY = 1'b1;
          else begin M_AXI_WREADY = 1'b0; w_cnt++; end
        end else begin
          M_AXI_WREADY = 1'b0; w_cnt = 0;
          if (rand_mode) w_wait = $urandom_range(0, 3);
        end
        if (M_AXI_ARVALID) begin
          if (ar_cnt >= ar_wait) M_AXI_ARREADY = 1'b1;
          else begin M_AXI_ARREADY = 1'b0; ar_cnt++; end
        end else begin
          M_AXI_ARREADY = 1'b0; ar_cnt = 0;
          if (rand_mode) ar_wait = $urandom_range(0, 3);
        end
        if (M_AXI_AWVALID && M_AXI_AWREADY) last_awaddr = M_AXI_AWADDR;
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          last_wdata = M_AXI_WDATA;
          last_wstrb = M_AXI_WSTRB;
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) last_araddr = M_AXI_ARADDR;
        if (M_AXI_BREADY) begin
          if (b_cnt >= b_wait) begin
            M_AXI_BVALID = 1'b1;
            M_AXI_BRESP  = resp_fn(last_awaddr);
          end else begin M_AXI_BVALID = 1'b0; b_cnt++; end
        end else begin
          M_AXI_BVALID = 1'b0; b_cnt = 0;
          if (rand_mode) b_wait = $urandom_range(0, 3);
        end
        if (M_AXI_RREADY) begin
          if (r_cnt >= r_wait) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = rdata_fn(last_araddr);
            M_AXI_RRESP  = resp_fn(last_araddr);
          end else begin M_AXI_RVALID = 1'b0; r_cnt++; end
        end else begin
          M_AXI_RVALID = 1'b0; r_cnt = 0;
          if (rand_mode) r_wait = $urandom_range(0, 3);
        end
      end
    end
  end

  // ---------------- scoreboard: compare each done pulse against its queue ----------------
  initial begin
    logic [EW-1:0] e;
    int id;
    forever begin
      @(negedge clk);
      if (req_done != 2'b00) begin
        checks++;
        if (req_done == 2'b11) begin
          errors++;
          $display("FAIL done_onehot: req_done=%b, required one-hot", req_done);
        end
        id = req_done[1] ? 1 : 0;
        done_log.push_back(id);
        checks++;
        if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
          errors++;
          $display("FAIL unexpected_done: req_done=%b with no pending request", req_done);
        end else begin
          e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (req_resp !== e[1:0]) begin
            errors++;
            $display("FAIL resp_%0d: got %b, required %b", id, req_resp, e[1:0]);
          end
          checks++;
          if (e[70]) begin
            if (last_awaddr !== e[69:38] || last_wdata !== e[37:6] || last_wstrb !== e[5:2]) begin
              errors++;
              $display("FAIL write_bus_%0d: addr/data/strb %h/%h/%h, required %h/%h/%h", id,
                       last_awaddr, last_wdata, last_wstrb, e[69:38], e[37:6], e[5:2]);
            end
          end else begin
            if (req_rdata !== e[37:6] || last_araddr !== e[69:38]) begin
              errors++;
              $display("FAIL read_%0d: rdata/araddr %h/%h, required %h/%h", id,
                       req_rdata, last_araddr, e[37:6], e[69:38]);
            end
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int id, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] d;
    int n;
    d = we ? data : rdata_fn(addr);
    if (id == 0) exp_q0.push_back({we, addr, d, strb, resp_fn(addr)});
    else         exp_q1.push_back({we, addr, d, strb, resp_fn(addr)});
    req_we[id]             = we;
    req_addr[id*32 +: 32]  = addr;
    req_wdata[id*32 +: 32] = data;
    req_wstrb[id*4 +: 4]   = strb;
    req_valid[id]          = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 300 && !req_done[id]);
    checks++;
    if (!req_done[id]) begin
      errors++;
      $display("FAIL timeout_%0d: no done after %0d cycles, required done", id, n);
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic set_waits(input int aw, input int w, input int b, input int ar, input int r);
    aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: aw/w/b/ar/r=%b, required 00000",
               {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
    end
    checks++;
    if (req_done !== 2'b00 || busy !== 1'b0 || req_rdata !== 32'h0 || req_resp !== 2'b00) begin
      errors++;
      $display("FAIL reset_req: done=%b busy=%b rdata=%h resp=%b, required all zero",
               req_done, busy, req_rdata, req_resp);
    end
    checks++;
    if (M_AXI_AWADDR !== 32'h0 || M_AXI_WDATA !== 32'h0 || M_AXI_WSTRB !== 4'h0 ||
        M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) begin
      errors++;
      $display("FAIL reset_regs: addr=%h data=%h strb=%h prot=%b/%b, required zero",
               M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_zero_wait();
    int n, aw_cycles, waddr_cycles, done_at;
    bit split_drop;
    n = 0; aw_cycles = 0; waddr_cycles = 0; done_at = 0; split_drop = 1'b0;
    set_waits(0, 0, 0, 0, 0);
    fork
      issue(0, 1'b1, 32'h0000_03FF, 32'hA5A5_0001, 4'hF);
      repeat (12) @(negedge clk) begin
        if (busy || n > 0) n++;
        if (n > 0) begin
          if (M_AXI_AWVALID) aw_cycles++;
          if (M_AXI_AWVALID || M_AXI_WVALID) waddr_cycles++;
          if (M_AXI_AWVALID != M_AXI_WVALID) split_drop = 1'b1;
          if (req_done[0] && done_at == 0) done_at = n;
        end
      end
    join
    checks++;
    if (done_at != 3) begin
      errors++;
      $display("FAIL wr_latency: done in cycle %0d after grant, required 3", done_at);
    end
    checks++;
    if (aw_cycles != 1 || waddr_cycles != 1 || split_drop) begin
      errors++;
      $display("FAIL wr_same_cycle: aw=%0d waddr=%0d split=%0d, required 1/1/0",
               aw_cycles, waddr_cycles, split_drop);
    end
  endtask

  task automatic test_read_waits();
    int n, ar_cycles, rr_cycles, done_at;
    bit unstable;
    n = 0; ar_cycles = 0; rr_cycles = 0; done_at = 0; unstable = 1'b0;
    set_waits(0, 0, 0, 2, 3);
    fork
      issue(1, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
      repeat (16) @(negedge clk) begin
        if (busy || n > 0) n++;
        if (n == 2) req_addr[63:32] = 32'hFFFF_FFFC;
        if (n > 0) begin
          if (M_AXI_ARVALID) ar_cycles++;
          if (M_AXI_ARVALID && M_AXI_ARADDR !== 32'h0) unstable = 1'b1;
          if (M_AXI_RREADY) rr_cycles++;
          if (req_done != 2'b00 && done_at == 0) done_at = n;
        end
      end
    join
    checks++;
    if (ar_cycles != 3 || unstable) begin
      errors++;
      $display("FAIL rd_arvalid: %0d cycles unstable=%0d, required 3 stable", ar_cycles, unstable);
    end
    checks++;
    if (rr_cycles != 4 || done_at != 8) begin
      errors++;
      $display("FAIL rd_timing: rready=%0d done_at=%0d, required 4/8", rr_cycles, done_at);
    end
  endtask

  task automatic test_write_split();
    int n, bready_at;
    bit w_first, bready_early;
    n = 0; bready_at = 0; w_first = 1'b0; bready_early = 1'b0;
    set_waits(4, 0, 0, 0, 0);
    fork
      issue(0, 1'b1, 32'h0000_2000, 32'hCAFE_0002, 4'h3);
      repeat (14) @(negedge clk) begin
        if (busy || n > 0) n++;
        if (n == 2 && M_AXI_AWVALID && !M_AXI_WVALID) w_first = 1'b1;
        if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) bready_early = 1'b1;
        if (n > 0 && M_AXI_BREADY && bready_at == 0) bready_at = n;
      end
    join
    checks++;
    if (!w_first || bready_early) begin
      errors++;
      $display("FAIL wr_split_order: w_first=%0d bready_early=%0d, required 1/0", w_first, bready_early);
    end
    checks++;
    if (bready_at != 6) begin
      errors++;
      $display("FAIL wr_split_bready: first in cycle %0d, required 6", bready_at);
    end
  endtask

  task automatic test_round_robin();
    set_waits(0, 0, 0, 0, 0);
    apply_reset();
    done_log.delete();
    fork
      begin
        issue(0, 1'b1, 32'h0000_0100, 32'h1111_0000, 4'hF);
        issue(0, 1'b1, 32'h0000_0104, 32'h1111_0001, 4'hF);
      end
      begin
        issue(1, 1'b1, 32'h0000_0200, 32'h2222_0000, 4'hF);
        issue(1, 1'b1, 32'h0000_0204, 32'h2222_0001, 4'hF);
      end
    join
    checks++;
    if (done_log.size() != 4 || done_log[0] != 0 || done_log[1] != 1 ||
        done_log[2] != 0 || done_log[3] != 1) begin
      errors++;
      $display("FAIL rr_order: %0d grants, order %p, required 0 1 0 1", done_log.size(), done_log);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_waits(0, 0, 0, 0, 10);
    req_we[1] = 1'b0;
    req_addr[63:32] = 32'h0000_0040;
    req_valid[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (n < 20 && !M_AXI_RREADY);
    checks++;
    if (!M_AXI_RREADY) begin
      errors++;
      $display("FAIL mid_reach_rdata: rready=%b, required 1", M_AXI_RREADY);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (M_AXI_RREADY !== 1'b0 || busy !== 1'b0 || req_done !== 2'b00 || M_AXI_ARVALID !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rready=%b busy=%b done=%b arvalid=%b, required 0",
               M_AXI_RREADY, busy, req_done, M_AXI_ARVALID);
    end
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_waits(0, 0, 0, 1, 1);
    issue(1, 1'b0, 32'h0000_1010, 32'h0, 4'h0);
  endtask

  task automatic test_random();
    rand_mode = 1'b1;
    fork
      for (int i = 0; i < 8; i++)
        issue(0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)));
      for (int j = 0; j < 8; j++)
        issue(1, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)));
    join
    rand_mode = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_write_split();
    test_round_robin();
    test_reset_mid();
    test_random();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d pending, required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
